// File: rtl/tile_map_scheduler_if.sv
// Bundles the scheduler's request, timing and drawer-facing signals.
// master = game logic / loader / drawer side, slave = the scheduler.
interface tile_map_scheduler_if #(
  parameter int MAP_ROWS = 12,
  parameter int MAP_COLS = 17
);
  logic signed [31:0]                      row;
  logic                                    req0_valid;
  logic                                    req0_ready;
  logic [3:0]                              req0_row;
  logic [4:0]                              req0_col;
  logic [7:0]                              req0_tile;
  logic                                    req1_valid;
  logic                                    req1_ready;
  logic [3:0]                              req1_row;
  logic [4:0]                              req1_col;
  logic [7:0]                              req1_tile;
  logic signed [31:0]                      mario_x_in;
  logic signed [31:0]                      mario_y_in;
  logic signed [31:0]                      mario_x;
  logic signed [31:0]                      mario_y;
  logic [MAP_ROWS-1:0][MAP_COLS-1:0][7:0]  background;
  logic                                    frame_start;
  logic [7:0]                              drop_count;

  modport master (
    output row,
    output req0_valid, req0_row, req0_col, req0_tile,
    output req1_valid, req1_row, req1_col, req1_tile,
    output mario_x_in, mario_y_in,
    input  req0_ready, req1_ready,
    input  mario_x, mario_y, background, frame_start, drop_count
  );

  modport slave (
    input  row,
    input  req0_valid, req0_row, req0_col, req0_tile,
    input  req1_valid, req1_row, req1_col, req1_tile,
    input  mario_x_in, mario_y_in,
    output req0_ready, req1_ready,
    output mario_x, mario_y, background, frame_start, drop_count
  );
endinterface

// File: rtl/tile_map_scheduler.sv
// Tile map / Mario position owner for the VGA drawer. All map writes and
// position snapshots happen only inside vertical blanking so the drawer
// always sees a consistent frame. Two requesters share the write path
// through a round-robin arbiter, with a per-vblank write budget.
module tile_map_scheduler #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAP_ROWS      = 12,
  parameter int MAP_COLS      = 17,
  parameter int SKY           = 1,
  parameter int GND           = 3,
  parameter int MAX_WRITES    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tile_map_scheduler_if.slave   bus
);

  localparam int         WCNT_W = $clog2(MAX_WRITES + 1);
  localparam logic [7:0] SKY_T  = 8'(SKY);
  localparam logic [7:0] GND_T  = 8'(GND);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_SNAP,
    ST_UPDATE
  } state_t;

  typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0][7:0] map_t;

  state_t             state_q, state_d;
  logic               vb_q, vb_d;
  map_t               map_q, map_d;
  map_t               map_rst;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               last1_q, last1_d;     // 1: requester 1 was granted last
  logic [7:0]         drop_q, drop_d;
  logic signed [31:0] mario_x_q, mario_x_d;
  logic signed [31:0] mario_y_q, mario_y_d;

  logic               rdy0, rdy1;
  logic               frame_start;
  logic [3:0]         sel_row;
  logic [4:0]         sel_col;
  logic [7:0]         sel_tile;
  logic               sel_oor;

  // Power-on map image: sky everywhere except the two ground rows at the bottom.
  for (genvar gi = 0; gi < MAP_ROWS; gi++) begin : g_map_rst
    assign map_rst[gi] = {MAP_COLS{(gi >= MAP_ROWS - 2) ? GND_T : SKY_T}};
  end

  // Vblank flag is registered from the drawer's row counter.
  assign vb_d = (bus.row >= SCREEN_HEIGHT);

  // Granted payload and its range check.
  always_comb begin
    sel_row  = rdy1 ? bus.req1_row  : bus.req0_row;
    sel_col  = rdy1 ? bus.req1_col  : bus.req0_col;
    sel_tile = rdy1 ? bus.req1_tile : bus.req0_tile;
    sel_oor  = (sel_row > 4'(MAP_ROWS - 1)) || (sel_col > 5'(MAP_COLS - 1));
  end

  // Next-state, arbitration and datapath updates.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    last1_d     = last1_q;
    drop_d      = drop_q;
    map_d       = map_q;
    mario_x_d   = mario_x_q;
    mario_y_d   = mario_y_q;
    rdy0        = 1'b0;
    rdy1        = 1'b0;
    frame_start = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        if (vb_q) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        frame_start = 1'b1;
        mario_x_d   = bus.mario_x_in;
        mario_y_d   = bus.mario_y_in;
        wcnt_d      = '0;
        state_d     = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (!vb_q) begin
          // Blanking is over: anything still pending waits for the next frame.
          state_d = ST_ACTIVE;
        end else if (wcnt_q < WCNT_W'(MAX_WRITES)) begin
          if (bus.req0_valid && bus.req1_valid) begin
            rdy0 = last1_q;
            rdy1 = !last1_q;
          end else begin
            rdy0 = bus.req0_valid;
            rdy1 = bus.req1_valid;
          end
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    // A ready is only raised with its valid, so ready alone marks a transfer.
    if (rdy0 || rdy1) begin
      wcnt_d  = wcnt_q + 1'b1;
      last1_d = rdy1;
      if (sel_oor) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        map_d[sel_row][sel_col] = sel_tile;
      end
    end
  end

  // State and datapath registers; reset restores the default map.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_ACTIVE;
      vb_q      <= 1'b0;
      map_q     <= map_rst;
      wcnt_q    <= '0;
      last1_q   <= 1'b1;
      drop_q    <= 8'd0;
      mario_x_q <= '0;
      mario_y_q <= '0;
    end else begin
      state_q   <= state_d;
      vb_q      <= vb_d;
      map_q     <= map_d;
      wcnt_q    <= wcnt_d;
      last1_q   <= last1_d;
      drop_q    <= drop_d;
      mario_x_q <= mario_x_d;
      mario_y_q <= mario_y_d;
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.frame_start = frame_start;
  assign bus.background  = map_q;
  assign bus.mario_x     = mario_x_q;
  assign bus.mario_y     = mario_y_q;
  assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed bench for tile_map_scheduler: reset image, snapshot, round-robin
// table, stall outside vblank, per-frame write budget with drops, reset mid-burst.
module tb_tile_map_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tile_map_scheduler_if bus ();

  tile_map_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v0;
    logic [3:0] r0;
    logic [4:0] c0;
    logic [7:0] t0;
    logic       v1;
    logic [3:0] r1;
    logic [4:0] c1;
    logic [7:0] t1;
    logic       e0;
    logic       e1;
  } vec_t;

  vec_t tbl[7];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row enters vblank; walks ACTIVE -> SNAP -> UPDATE, returning in the first UPDATE cycle.
  task automatic goto_update();
    bus.row = 480;
    step();
    chk("pre_snap_fs", bus.frame_start, 0);
    chk("pre_snap_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    step();
    chk("snap_fs", bus.frame_start, 1);
    chk("snap_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    step();
    chk("update_fs", bus.frame_start, 0);
  endtask

  task automatic end_frame();
    bus.row = 0;
    step();
    chk("vb_exit_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    step();
  endtask

  function automatic logic is_oor(input int k);
    return (k == 3) || (k == 10) || (k == 17) || (k == 24) || (k == 35);
  endfunction

  // Back-to-back req0 writes from a 40-entry list; k is the next write index.
  task automatic burst(input int cycles, inout int k);
    logic got;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (k < 40) begin
        bus.req0_valid = 1'b1;
        bus.req0_row   = is_oor(k) ? 4'd13 : 4'(k % 10);
        bus.req0_col   = 5'(k % 17);
        bus.req0_tile  = 8'(8'h40 + k);
      end else begin
        bus.req0_valid = 1'b0;
      end
      #1;
      got = bus.req0_ready;
      step();
      if (got) begin
        $display("burst write %0d accepted", k);
        k++;
      end
    end
  endtask

  initial begin
    int k;

    // Round-robin table: losers hold their payload, winners advance.
    tbl[0] = '{1'b1, 4'd1, 5'd1, 8'hA0, 1'b1, 4'd2, 5'd1, 8'hB0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 4'd1, 5'd2, 8'hA1, 1'b1, 4'd2, 5'd1, 8'hB0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 4'd1, 5'd2, 8'hA1, 1'b1, 4'd2, 5'd2, 8'hB1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'd1, 5'd3, 8'hA2, 1'b1, 4'd2, 5'd2, 8'hB1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 4'd1, 5'd3, 8'hA2, 1'b1, 4'd2, 5'd3, 8'hB2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'd0, 5'd0, 8'h00, 1'b1, 4'd2, 5'd3, 8'hB2, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 4'd0, 5'd0, 8'h00, 1'b0, 4'd0, 5'd0, 8'h00, 1'b0, 1'b0};

    reset_n = 1'b0;
    bus.row = 0;
    bus.req0_valid = 1'b0; bus.req0_row = '0; bus.req0_col = '0; bus.req0_tile = '0;
    bus.req1_valid = 1'b0; bus.req1_row = '0; bus.req1_col = '0; bus.req1_tile = '0;
    bus.mario_x_in = 0;
    bus.mario_y_in = 0;

    // Reset image
    step(); step();
    reset_n = 1'b1;
    step();
    chk("rst_bg_5_3", bus.background[5][3], 1);
    chk("rst_bg_9_16", bus.background[9][16], 1);
    chk("rst_bg_10_16", bus.background[10][16], 3);
    chk("rst_bg_11_0", bus.background[11][0], 3);
    chk("rst_mario_x", bus.mario_x, 0);
    chk("rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_drop", bus.drop_count, 0);

    // Single write and frame snapshot
    bus.mario_x_in = 100;
    bus.mario_y_in = 200;
    bus.row = 479;
    step();
    chk("active_mario_hold", bus.mario_x, 0);
    goto_update();
    chk("snap_mario_x", bus.mario_x, 100);
    chk("snap_mario_y", bus.mario_y, 200);
    bus.req0_valid = 1'b1; bus.req0_row = 4'd4; bus.req0_col = 5'd7; bus.req0_tile = 8'd2;
    #1;
    chk("single_rdy0", bus.req0_ready, 1);
    chk("single_bg_before", bus.background[4][7], 1);
    step();
    bus.req0_valid = 1'b0;
    chk("single_bg_after", bus.background[4][7], 2);
    $display("single write row 4 col 7 tile 2 done");
    end_frame();

    // Stall outside vblank: req1 only, accepted in first UPDATE cycle
    bus.row = 100;
    bus.req1_valid = 1'b1; bus.req1_row = 4'd6; bus.req1_col = 5'd16; bus.req1_tile = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdy1", bus.req1_ready, 0);
    end
    goto_update();
    chk("stall_first_update_rdy1", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0;
    chk("stall_bg", bus.background[6][16], 8'h55);
    $display("stalled req1 write accepted");
    end_frame();

    // Round-robin table
    goto_update();
    for (int i = 0; i < 7; i++) begin
      bus.req0_valid = tbl[i].v0; bus.req0_row = tbl[i].r0;
      bus.req0_col = tbl[i].c0;   bus.req0_tile = tbl[i].t0;
      bus.req1_valid = tbl[i].v1; bus.req1_row = tbl[i].r1;
      bus.req1_col = tbl[i].c1;   bus.req1_tile = tbl[i].t1;
      #1;
      chk($sformatf("rr%0d_rdy0", i), bus.req0_ready, tbl[i].e0);
      chk($sformatf("rr%0d_rdy1", i), bus.req1_ready, tbl[i].e1);
      step();
      if (tbl[i].e0) chk($sformatf("rr%0d_bg0", i), bus.background[tbl[i].r0][tbl[i].c0], tbl[i].t0);
      if (tbl[i].e1) chk($sformatf("rr%0d_bg1", i), bus.background[tbl[i].r1][tbl[i].c1], tbl[i].t1);
      $display("rr vector %0d: v0=%0b v1=%0b expect rdy0=%0b rdy1=%0b", i, tbl[i].v0, tbl[i].v1, tbl[i].e0, tbl[i].e1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    end_frame();

    // Per-frame write limit with drops
    k = 0;
    goto_update();
    burst(36, k);
    chk("limit_accepted", k, 32);
    chk("limit_rdy_low", bus.req0_ready, 0);
    end_frame();
    chk("limit_drop_f1", bus.drop_count, 4);
    chk("limit_bg_w31", bus.background[1][14], 8'h5F);
    chk("limit_bg_w32_pending", bus.background[2][15], 1);
    goto_update();
    burst(10, k);
    chk("limit_all_done", k, 40);
    end_frame();
    chk("limit_drop_f2", bus.drop_count, 5);
    chk("limit_bg_w32", bus.background[2][15], 8'h60);
    chk("limit_bg_w39", bus.background[9][5], 8'h67);

    // Reset during a write burst
    goto_update();
    bus.req0_valid = 1'b1; bus.req0_row = 4'd5; bus.req0_col = 5'd5; bus.req0_tile = 8'h77;
    step();
    chk("mid_bg_written", bus.background[5][5], 8'h77);
    reset_n = 1'b0;
    step();
    chk("mid_rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    chk("mid_rst_bg_5_5", bus.background[5][5], 1);
    chk("mid_rst_bg_4_7", bus.background[4][7], 1);
    chk("mid_rst_bg_11_3", bus.background[11][3], 3);
    chk("mid_rst_drop", bus.drop_count, 0);
    chk("mid_rst_mario", bus.mario_x, 0);
    chk("mid_rst_fs", bus.frame_start, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_rdy", {bus.req0_ready, bus.req1_ready}, 0);
    step();
    chk("post_rst_rdy2", {bus.req0_ready, bus.req1_ready}, 0);
    bus.req0_valid = 1'b0;
    $display("reset during burst done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_map_scheduler.md
Name: tile_map_scheduler

Overview:
- Owns the 12x17 background tile map and the Mario position fed to the VGA drawer.
- Tile-write requests come from two requesters: req0 (game logic, e.g. block hit) and req1 (scroll/level loader).
- Tile writes and position updates are applied only during vertical blanking, so the drawer never shows a half-updated frame.
- Sits between game logic and the VGA drawer; it takes the drawer's row counter as its timing reference.

Parameters:
- SCREEN_HEIGHT, 480: first non-visible row; row >= this is vblank.
- MAP_ROWS, 12: tile map rows.
- MAP_COLS, 17: tile map columns.
- SKY, 1: reset tile code for rows 0..MAP_ROWS-3.
- GND, 3: reset tile code for the last two rows.
- MAX_WRITES, 32: maximum accepted writes per vblank, in-range and dropped combined.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- row  in  32 (int)  current VGA row from the timing generator.
- req0_valid  in  1  requester 0 has a tile write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_row  in  4  target tile row.
- req0_col  in  5  target tile column.
- req0_tile  in  8  tile code to write.
- req1_valid / req1_ready / req1_row / req1_col / req1_tile: same as req0, for requester 1.
- mario_x_in, mario_y_in  in  32 (int) each  live Mario position from physics.
- mario_x, mario_y  out  32 (int) each  per-frame snapshot driven to the drawer.
- background  out  byte [11:0][16:0]  tile map driven to the drawer.
- frame_start  out  1  one-cycle pulse on vblank entry.
- drop_count  out  8  saturating count of out-of-range writes.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=ACTIVE; rows 0..9 = SKY, rows 10..11 = GND.
  - mario_x = mario_y = 0; frame_start = 0; drop_count = 0; write count = 0.
  - Round-robin pointer set so req0 wins the first tie.
  - Reset mid-UPDATE discards any in-flight grant and restores the map.
- Registered vblank flag: vb <= (row >= SCREEN_HEIGHT).
- ACTIVE:
  - No readies asserted; map and snapshot held.
  - If vb=1, go to SNAP.
- SNAP (exactly one cycle):
  - mario_x/mario_y <= mario_x_in/mario_y_in.
  - frame_start = 1 this cycle.
  - Write count cleared.
  - No readies. Next state is UPDATE.
- UPDATE:
  - At most one ready high per cycle.
  - Ready is combinational from state, valid, write count and the RR pointer.
  - Arbitration:
    - Only one valid: that requester is granted.
    - Both valid: grant the requester not granted last.
    - Pointer updates only on an accepted transfer.
  - Transfer occurs when valid && ready at a clk edge.
  - The map entry updates at that edge and is visible on background the next cycle (latency 1).
  - Out-of-range target (row > 11 or col > 16):
    - Still accepted (ready high) and counts toward MAX_WRITES.
    - Map unchanged; drop_count += 1, saturating at 255.
  - When write count == MAX_WRITES, both readies stay low until the next SNAP.
  - If vb=0, go to ACTIVE.
    - No ready is asserted in the cycle vb is sampled 0.
    - Pending requests wait for the next frame.
- Requesters must hold valid and payload stable until ready. The block does not sample the payload without ready.
- Multiple writes to the same tile in one vblank: the last accepted write wins.
- drop_count is never cleared except by reset.

Test Plan:
- Reset value check:
  - Stimulus: hold reset_n=0 for 2 cycles, release; row=0.
  - Required: background[5][3]=1, background[11][0]=3, mario_x=0, both readies 0, frame_start=0.
- Single write and frame snapshot:
  - Stimulus: mario_x_in=100, mario_y_in=200; step row 479→480; req0 writes row 4, col 7, tile 2.
  - Required: frame_start pulses exactly once; mario_x=100, mario_y=200; background[4][7]=2 one cycle after the handshake.
- Round-robin arbitration:
  - Stimulus: both requesters held valid through vblank, each with 3 writes queued.
  - Required: grants alternate req0, req1, req0, req1, req0, req1; never both readies high in one cycle.
- Writes outside vblank are stalled:
  - Stimulus: req1_valid asserted at row=100.
  - Required: req1_ready stays 0 until after SNAP; the write is accepted in the first UPDATE cycle.
- Per-frame limit and drop counting:
  - Stimulus: 40 back-to-back writes, of which 5 target row 13.
  - Required: exactly 32 accepted this frame; drop_count increases only for the out-of-range writes among those 32; remaining writes complete in the next vblank.
- Reset mid-UPDATE:
  - Stimulus: assert reset_n=0 during a write burst.
  - Required: map returns to the SKY/GND default, state=ACTIVE, readies 0 on the next cycle.
